// File: rtl/key_expansion_seq_if.sv
// Bundles the key-schedule handshake, the key input, and the side path to the S-box stage.
// slave is the schedule generator; master is the driver/consumer side.
interface key_expansion_seq_if;
   logic         start;
   logic [127:0] key_in;
   logic [31:0]  sbox_in;
   logic [31:0]  sbox_out;
   logic [127:0] round_key;
   logic [3:0]   round_num;
   logic         round_valid;
   logic         round_ready;
   logic         busy;
   logic         done;

   modport slave (
      input  start, key_in, sbox_out, round_ready,
      output sbox_in, round_key, round_num, round_valid, busy, done
   );

   modport master (
      output start, key_in, sbox_out, round_ready,
      input  sbox_in, round_key, round_num, round_valid, busy, done
   );
endinterface

// File: rtl/key_expansion_seq.sv
// Sequential AES-128 key schedule: emits round keys 0..NUM_ROUNDS, one per valid/ready transfer.
// SubWord is performed by an external S-box stage fed from sbox_in within the same cycle.
module key_expansion_seq #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic                clk,
   input  logic                reset,
   key_expansion_seq_if.slave  bus
);
   typedef enum logic {IDLE, EMIT} state_t;

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   state_t       state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [3:0]   num_q, num_d;
   logic         valid_q, valid_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic [31:0]  t, w0n, w1n, w2n, w3n;
   logic [7:0]   rcon_next;

   assign bus.sbox_in     = {key_q[23:0], key_q[31:24]};
   assign bus.round_key   = key_q;
   assign bus.round_num   = num_q;
   assign bus.round_valid = valid_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

   // Chained word update: each new word depends on the one just produced.
   assign t   = bus.sbox_out ^ {rcon_q, 24'h0};
   assign w0n = key_q[127:96] ^ t;
   assign w1n = key_q[95:64]  ^ w0n;
   assign w2n = key_q[63:32]  ^ w1n;
   assign w3n = key_q[31:0]   ^ w2n;
   assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         key_q   <= '0;
         rcon_q  <= 8'h01;
         num_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         rcon_q  <= rcon_d;
         num_q   <= num_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      rcon_d  = rcon_q;
      num_d   = num_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               key_d   = bus.key_in;
               num_d   = '0;
               rcon_d  = 8'h01;
               busy_d  = 1'b1;
               valid_d = 1'b1;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (bus.round_ready) begin
               if (num_q == LAST_ROUND) begin
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  key_d  = {w0n, w1n, w2n, w3n};
                  num_d  = num_q + 4'd1;
                  rcon_d = rcon_next;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule
